// File: rtl/totient_pkg.sv
// Shared constants and types for the Euler-totient display sequencer.
package totient_pkg;

    // phi(n+1) for sequence position n = 0..15
    localparam logic [3:0] PHI_TABLE [0:15] = '{
        4'd1, 4'd1, 4'd2, 4'd2, 4'd4, 4'd2, 4'd6, 4'd4,
        4'd6, 4'd4, 4'd10, 4'd4, 4'd12, 4'd6, 4'd8, 4'd8
    };

    // Segment patterns, bit order {A,B,C,D,E,F,G}, active-high
    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/totient_display_sequencer_if.sv
// Control inputs and display outputs of the totient display sequencer.
interface totient_display_sequencer_if;
    logic       run;
    logic       step;
    logic       restart;
    logic [3:0] index;
    logic [3:0] value;
    logic       wrap;
    logic [1:0] an;
    logic       A, B, C, D, E, F, G;

    // Board side: buttons/switches in, display out
    modport master (
        output run, step, restart,
        input  index, value, wrap, an, A, B, C, D, E, F, G
    );

    // Sequencer side
    modport slave (
        input  run, step, restart,
        output index, value, wrap, an, A, B, C, D, E, F, G
    );
endinterface

// File: rtl/totient_seg_decode.sv
// Digit code to 7-segment pattern with blanking; undefined codes are dark.
module totient_seg_decode
    import totient_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    output logic [6:0] seg
);

    // Only the digits the totient sequence can produce have patterns
    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            case (code)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd4:    seg = SEG_4;
                4'd6:    seg = SEG_6;
                4'd8:    seg = SEG_8;
                default: seg = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/totient_display_sequencer.sv
// Steps phi(1)..phi(16) under run/step/restart and scans two shared-segment digits.
//
//   state | meaning
//   PAUSE | index held; step pulses advance it; tick counter frozen
//   RUN   | tick counter runs; index advances every TICK_DIV cycles
module totient_display_sequencer
    import totient_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int SCAN_DIV = 2
) (
    input  logic                        clk_0,
    input  logic                        R_n,
    totient_display_sequencer_if.slave  bus
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] tick_q, tick_d;
    logic [15:0] scan_q, scan_d;
    logic        digit_q, digit_d;     // 0 = ones, 1 = tens
    logic [3:0]  index_q, index_d;
    logic [3:0]  value_q, value_d;
    logic        wrap_q, wrap_d;
    logic [1:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        advance;
    logic        tens;
    logic        blank;
    logic [3:0]  digit_code;
    logic [6:0]  seg_dec;

    // Sequencing: restart beats run, run beats step; the entry edge into RUN does not count
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        index_d = index_q;
        wrap_d  = 1'b0;
        advance = 1'b0;
        if (bus.restart) begin
            index_d = 4'd0;
            tick_d  = 16'd0;
        end else begin
            if (state_q == PAUSE) begin
                if (bus.run) begin
                    state_d = RUN;
                end else if (bus.step) begin
                    advance = 1'b1;
                end
            end else begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = 16'd0;
                    advance = 1'b1;
                end else begin
                    tick_d = tick_q + 16'd1;
                end
                if (!bus.run) begin
                    state_d = PAUSE;
                end
            end
            if (advance) begin
                index_d = index_q + 4'd1;
                wrap_d  = (index_q == 4'd15);
            end
        end
        value_d = PHI_TABLE[index_d];
    end

    // Free-running digit scan, unaffected by run/step/restart
    always_comb begin
        scan_d  = scan_q + 16'd1;
        digit_d = digit_q;
        if (scan_q == SCAN_LAST) begin
            scan_d  = 16'd0;
            digit_d = ~digit_q;
        end
    end

    // Split the current value into the active digit; a zero tens digit is blanked
    always_comb begin
        tens       = (value_q >= 4'd10);
        digit_code = digit_q ? {3'b000, tens} : (tens ? value_q - 4'd10 : value_q);
        blank      = digit_q & ~tens;
        an_d       = digit_q ? 2'b10 : 2'b01;
        seg_d      = seg_dec;
    end

    totient_seg_decode u_seg_decode (
        .code  (digit_code),
        .blank (blank),
        .seg   (seg_dec)
    );

    // State and registered outputs; an/seg lag the index/digit by one cycle
    always_ff @(posedge clk_0 or negedge R_n) begin
        if (!R_n) begin
            state_q <= PAUSE;
            tick_q  <= 16'd0;
            scan_q  <= 16'd0;
            digit_q <= 1'b0;
            index_q <= 4'd0;
            value_q <= 4'd1;
            wrap_q  <= 1'b0;
            an_q    <= 2'b00;
            seg_q   <= SEG_OFF;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            scan_q  <= scan_d;
            digit_q <= digit_d;
            index_q <= index_d;
            value_q <= value_d;
            wrap_q  <= wrap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.index = index_q;
    assign bus.value = value_q;
    assign bus.wrap  = wrap_q;
    assign bus.an    = an_q;
    assign bus.A     = seg_q[6];
    assign bus.B     = seg_q[5];
    assign bus.C     = seg_q[4];
    assign bus.D     = seg_q[3];
    assign bus.E     = seg_q[2];
    assign bus.F     = seg_q[1];
    assign bus.G     = seg_q[0];

endmodule

// File: tb/tb_totient_display_sequencer.sv
// Self-checking bench: vector table, directed corner sequences, random run against a reference model.
module tb_totient_display_sequencer;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    totient_display_sequencer_if bus();

    totient_display_sequencer #(
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk_0 (clk),
        .R_n   (rst_n),
        .bus   (bus)
    );

    logic [6:0] seg_obs;
    assign seg_obs = {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G};

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit         m_running;
    bit         m_tens;
    int         m_idx;
    int         m_tick;
    int         m_scan;
    logic       exp_wrap;
    logic [1:0] exp_an;
    logic [6:0] exp_seg;

    typedef struct {
        bit run;
        bit step;
        bit restart;
        int idx;
        int val;
        bit wrap;
    } vec_t;

    vec_t vecs [13];

    function automatic int gcd(int a, int b);
        int t;
        while (b != 0) begin
            t = b;
            b = a % b;
            a = t;
        end
        return a;
    endfunction

    function automatic int phi(int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (gcd(k, n) == 1) c++;
        return c;
    endfunction

    function automatic logic [6:0] digit_pattern(int d);
        case (d)
            0:       return 7'b1111110;
            1:       return 7'b0110000;
            2:       return 7'b1101101;
            4:       return 7'b0110011;
            6:       return 7'b1011111;
            8:       return 7'b1111111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] seg_for(int v, bit tens_sel);
        if (tens_sel) return (v >= 10) ? digit_pattern(1) : 7'b0000000;
        return digit_pattern(v % 10);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_running = 0;
        m_tens    = 0;
        m_idx     = 0;
        m_tick    = 0;
        m_scan    = 0;
        exp_wrap  = 1'b0;
        exp_an    = 2'b00;
        exp_seg   = 7'b0000000;
    endtask

    task automatic model_advance();
        exp_wrap = (m_idx == 15);
        m_idx    = (m_idx + 1) % 16;
    endtask

    task automatic model_edge(input bit r, input bit s, input bit rs);
        exp_an  = m_tens ? 2'b10 : 2'b01;
        exp_seg = seg_for(phi(m_idx + 1), m_tens);
        m_scan++;
        if (m_scan == SCAN_DIV) begin
            m_scan = 0;
            m_tens = !m_tens;
        end
        exp_wrap = 1'b0;
        if (rs) begin
            m_idx  = 0;
            m_tick = 0;
        end else if (!m_running) begin
            if (r) m_running = 1;
            else if (s) model_advance();
        end else begin
            m_tick++;
            if (m_tick == TICK_DIV) begin
                m_tick = 0;
                model_advance();
            end
            if (!r) m_running = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " index"}, int'(bus.index), m_idx);
        check({tag, " value"}, int'(bus.value), phi(m_idx + 1));
        check({tag, " wrap"},  int'(bus.wrap),  int'(exp_wrap));
        check({tag, " an"},    int'(bus.an),    int'(exp_an));
        check({tag, " seg"},   int'(seg_obs),   int'(exp_seg));
    endtask

    // Called at a negedge; returns at the following negedge after checking
    task automatic cyc(input bit r, input bit s, input bit rs, input string tag);
        bus.run     = r;
        bus.step    = s;
        bus.restart = rs;
        @(posedge clk);
        model_edge(r, s, rs);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        bus.run     = 1'b0;
        bus.step    = 1'b0;
        bus.restart = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        int wraps;
        bit seen_tens, seen_ones;
        bit rr;

        vecs[0]  = '{0, 1, 0, 1, 1, 0};
        vecs[1]  = '{0, 1, 0, 2, 2, 0};
        vecs[2]  = '{0, 0, 0, 2, 2, 0};
        vecs[3]  = '{0, 0, 1, 0, 1, 0};
        vecs[4]  = '{0, 1, 0, 1, 1, 0};
        vecs[5]  = '{1, 1, 0, 1, 1, 0};
        vecs[6]  = '{1, 1, 0, 1, 1, 0};
        vecs[7]  = '{1, 0, 0, 1, 1, 0};
        vecs[8]  = '{1, 0, 0, 1, 1, 0};
        vecs[9]  = '{1, 0, 0, 2, 2, 0};
        vecs[10] = '{0, 0, 0, 2, 2, 0};
        vecs[11] = '{0, 1, 0, 3, 2, 0};
        vecs[12] = '{0, 1, 1, 0, 1, 0};

        bus.run = 1'b0;
        bus.step = 1'b0;
        bus.restart = 1'b0;

        // Idle scan after reset: an alternates every 2 cycles, tens blanked
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 0, "idle");
            check("idle an", int'(bus.an), (((k - 1) / 2) % 2 == 1) ? 2 : 1);
            check("idle seg", int'(seg_obs), (bus.an == 2'b01) ? 7'b0110000 : 7'b0000000);
        end

        // Vector table
        do_reset();
        for (int i = 0; i < 13; i++) begin
            cyc(vecs[i].run, vecs[i].step, vecs[i].restart, "vec");
            check($sformatf("vec%0d index", i), int'(bus.index), vecs[i].idx);
            check($sformatf("vec%0d value", i), int'(bus.value), vecs[i].val);
            check($sformatf("vec%0d wrap", i),  int'(bus.wrap),  int'(vecs[i].wrap));
        end

        // Full lap in RUN: one wrap pulse, index back at 0
        do_reset();
        wraps = 0;
        for (int k = 0; k < 65; k++) begin
            cyc(1, 0, 0, "lap");
            if (bus.wrap) begin
                wraps++;
                check("lap wrap at index", int'(bus.index), 0);
            end
        end
        check("lap wrap count", wraps, 1);
        check("lap final index", int'(bus.index), 0);

        // Eleven steps while paused, then step in RUN does nothing extra
        do_reset();
        for (int k = 0; k < 11; k++) cyc(0, 1, 0, "step11");
        check("step11 index", int'(bus.index), 11);
        check("step11 value", int'(bus.value), 4);
        cyc(1, 0, 0, "enter run");
        cyc(1, 1, 0, "step in run");
        check("step in run index", int'(bus.index), 11);

        // Display of 12 (tens 1, ones 2) and 10 (ones 0)
        do_reset();
        for (int k = 0; k < 12; k++) cyc(0, 1, 0, "to12");
        cyc(0, 0, 0, "hold12");
        cyc(0, 0, 0, "hold12");
        seen_tens = 0;
        seen_ones = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, "show12");
            if (bus.an == 2'b10) begin
                seen_tens = 1;
                check("12 tens seg", int'(seg_obs), 7'b0110000);
            end else begin
                seen_ones = 1;
                check("12 ones seg", int'(seg_obs), 7'b1101101);
            end
        end
        check("12 both digits scanned", int'({seen_tens, seen_ones}), 3);
        cyc(0, 0, 1, "restart");
        for (int k = 0; k < 10; k++) cyc(0, 1, 0, "to10");
        cyc(0, 0, 0, "hold10");
        cyc(0, 0, 0, "hold10");
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, "show10");
            if (bus.an == 2'b01) check("10 ones seg", int'(seg_obs), 7'b1111110);
        end

        // Restart coinciding with terminal count at index 15
        do_reset();
        for (int k = 0; k < 15; k++) cyc(0, 1, 0, "to15");
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, "count");
        check("pre-restart index", int'(bus.index), 15);
        cyc(1, 0, 1, "restart at tc");
        check("restart at tc index", int'(bus.index), 0);
        check("restart at tc wrap", int'(bus.wrap), 0);
        cyc(1, 0, 0, "after restart");
        check("after restart wrap", int'(bus.wrap), 0);
        check("after restart index", int'(bus.index), 0);

        // Pause at tick count 2, hold, resume: advance two edges after resuming
        do_reset();
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, "pre-pause");
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, "paused");
        cyc(1, 0, 0, "resume");
        check("resume index", int'(bus.index), 0);
        cyc(1, 0, 0, "resume+1");
        check("resume+1 index", int'(bus.index), 1);

        // Asynchronous reset mid-run
        for (int k = 0; k < 7; k++) cyc(1, 0, 0, "run");
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async reset");
        check("async reset an", int'(bus.an), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Random stimulus against the model
        do_reset();
        rr = 0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0) rr = !rr;
            cyc(rr, ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/totient_display_sequencer.md
# totient_display_sequencer

Controller that sequences the Euler-totient display: it steps a 4-bit index through φ(1)..φ(16) under run/step/restart control, paced by a tick divider. It also time-multiplexes two 7-segment digits (tens, ones) over a shared segment bus. It sits between the board push-buttons and switches and the two-digit common-segment display, replacing the free-running single-digit counter path.

## Interface
Parameters:
- TICK_DIV, default 4: clock cycles per index advance while running; legal range 1..65535.
- SCAN_DIV, default 2: clock cycles each digit is held active before switching; legal range 1..65535.

Ports:
- clk_0  in  1  single clock; all state updates on its rising edge.
- R_n  in  1  reset, asynchronous assert, active-low.
- run  in  1  level; 1 = auto-advance, 0 = paused.
- step  in  1  synchronous one-cycle pulse; advances the index by one while paused.
- restart  in  1  synchronous one-cycle pulse; index and tick counter return to 0.
- index  out  4  current sequence position n; the displayed value is φ(n+1).
- value  out  4  φ(index+1), binary.
- wrap  out  1  one-cycle pulse in the cycle after the index goes 15→0.
- an  out  2  digit enable, one-hot, active-high; an[0] = ones, an[1] = tens.
- A, B, C, D, E, F, G  out  1 each  segment drives, active-high, shared by both digits.

## Operation
- Sequence table, index 0..15: 1,1,2,2,4,2,6,4,6,4,10,4,12,6,8,8.
- State machine states:
  - PAUSE (reset state).
  - RUN.
- State transitions:
  - PAUSE→RUN when run=1.
  - RUN→PAUSE when run=0.
- Tick counter:
  - Counts 0..TICK_DIV-1 only in RUN.
  - On terminal count the index advances and the counter returns to 0.
  - In PAUSE the counter holds its value; it is not cleared.
- Step: in PAUSE, step=1 advances the index by one. In RUN, step is ignored.
- Index wraps 15→0 on every advance path, auto or step. wrap=1 in the following cycle.
- Priority within one cycle, highest first:
  1. restart. It clears the index and tick counter and suppresses any advance and wrap. The state is unchanged.
  2. run. When run=1 in PAUSE in the same cycle as step, the step is ignored and the state goes to RUN.
  3. step / terminal count.
- Digit split:
  - tens = 1 if value ≥ 10, else 0.
  - ones = value − 10 if value ≥ 10, else value.
  - A tens digit of 0 is blanked (all segments 0).
- Segment codes {A..G}:
  - 0 = 1111110
  - 1 = 0110000
  - 2 = 1101101
  - 4 = 0110011
  - 6 = 1011111
  - 8 = 1111111
  - Any other code outputs 0000000.
- Scan:
  - A free-running scan counter toggles the active digit every SCAN_DIV cycles, independent of run, step and restart.
  - an and the segment outputs always correspond to the same digit.

## Timing
- Reset values (R_n=0):
  - state = PAUSE
  - index = 0, value = 1
  - tick counter = 0, scan counter = 0, active digit = ones
  - wrap = 0
  - an = 00
  - {A..G} = 0000000
- index, value and wrap are registered. An index change is visible on the edge that accepts the step or terminal count.
- an and {A..G} are registered from the index and active digit of the previous cycle, giving one cycle of display latency.
  - First edge after reset release: an = 01 and {A..G} = 0110000.
- Auto-advance period in RUN is exactly TICK_DIV cycles. With TICK_DIV=1 the index advances every cycle.
- Pausing mid-count and then resuming finishes the remaining count; no cycles are lost or added.
- Reset asserted mid-operation returns all outputs to reset values immediately, without waiting for a clock edge.

## Structure
- Shared package totient_pkg holds:
  - the 16-entry φ table constant;
  - the seven segment-code constants;
  - the state enum (PAUSE, RUN).
- Sub-module totient_seg_decode: combinational 4-bit→7-segment decode plus blanking input, instanced once on the shared bus.
- The top level holds the FSM, tick counter, scan counter and output registers.

## Test plan
- Reset, run=0, 10 cycles → index=0, value=1, an alternates 01/10 every 2 cycles. Segments are 0110000 on ones and 0000000 (blank) on tens.
- run=1 with TICK_DIV=4 for 64 cycles → index steps once every 4 cycles through all 16 values. wrap pulses once, in the cycle after index returns to 0.
- Paused; pulse step 11 times → index=11, value=4. step asserted in RUN → no extra advance.
- Index at 12, scan on tens → {A..G}=0110000; scan on ones → 1101101. Index 10 ones → 1111110.
- restart in the same cycle as a terminal count at index 15 → index=0, no wrap pulse. Simultaneous run=1 and step in PAUSE → state RUN, index unchanged.
- Drop run at tick count 2, hold 5 cycles, raise run → the advance occurs 2 cycles later. R_n pulled low mid-run → all outputs at reset values before the next edge.
